// File: rtl/kyo_stand_fetch.sv
// Kyo standing-sprite pixel fetcher: box test, flipped/animated ROM address,
// three-edge pixel pipeline to the palette stage, and the stand-animation counter.
module kyo_stand_fetch #(
    parameter int SPRITE_W        = 64,
    parameter int SPRITE_H        = 112,
    parameter int FRAMES          = 4,
    parameter int FRAME_TICKS     = 8,
    parameter int ADDR_W          = 15,
    parameter int TRANSPARENT_IDX = 15
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      pix_valid,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic                      frame_start,
    input  logic [9:0]                SpriteX,
    input  logic [9:0]                SpriteY,
    input  logic                      facing_left,
    input  logic                      anim_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [3:0]                rom_data,
    output logic [3:0]                pal_index,
    output logic                      pix_opaque,
    output logic                      out_valid,
    output logic [$clog2(FRAMES)-1:0] anim_frame
);

    localparam int FW = $clog2(FRAMES);
    localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [3:0] TIDX = 4'(TRANSPARENT_IDX);

    logic signed [10:0] rel_x_s, rel_y_s;
    logic               inside_s;
    logic [9:0]         col_s;
    logic [ADDR_W-1:0]  addr_s;
    logic [ADDR_W-1:0]  rom_addr_d, rom_addr_q;
    logic               inside_p1_q, valid_p1_q, inside_p2_q, valid_p2_q;
    logic [3:0]         pal_index_d, pal_index_q;
    logic               pix_opaque_d, pix_opaque_q, out_valid_q;
    logic [TW-1:0]      tick_d, tick_q;
    logic [FW-1:0]      anim_frame_d, anim_frame_q;

    // Zero-extended operands keep the difference signed, so screen wrap never aliases into the box.
    assign rel_x_s = $signed({1'b0, DrawX}) - $signed({1'b0, SpriteX});
    assign rel_y_s = $signed({1'b0, DrawY}) - $signed({1'b0, SpriteY});

    // Stage 0: box test, mirrored column and ROM address for the current pixel.
    always_comb begin
        inside_s   = 1'b0;
        col_s      = rel_x_s[9:0];
        rom_addr_d = rom_addr_q;
        if (pix_valid && !rel_x_s[10] && (rel_x_s[9:0] < 10'(SPRITE_W)) &&
            !rel_y_s[10] && (rel_y_s[9:0] < 10'(SPRITE_H))) begin
            inside_s = 1'b1;
        end else begin
            inside_s = 1'b0;
        end
        if (facing_left) begin
            col_s = 10'(SPRITE_W - 1) - rel_x_s[9:0];
        end else begin
            col_s = rel_x_s[9:0];
        end
        addr_s = ADDR_W'(anim_frame_q) * ADDR_W'(SPRITE_W * SPRITE_H)
               + ADDR_W'(rel_y_s[9:0]) * ADDR_W'(SPRITE_W)
               + ADDR_W'(col_s);
        if (inside_s) begin
            rom_addr_d = addr_s;
        end else begin
            rom_addr_d = rom_addr_q;
        end
    end

    // Stage 3 next-state: outside pixels read as the transparent key.
    always_comb begin
        pal_index_d  = TIDX;
        pix_opaque_d = 1'b0;
        if (inside_p2_q) begin
            pal_index_d  = rom_data;
            pix_opaque_d = (rom_data != TIDX);
        end else begin
            pal_index_d  = TIDX;
            pix_opaque_d = 1'b0;
        end
    end

    // Animation next-state: only enabled frame_start pulses count.
    always_comb begin
        tick_d       = tick_q;
        anim_frame_d = anim_frame_q;
        if (frame_start && anim_en) begin
            if (tick_q == TW'(FRAME_TICKS - 1)) begin
                tick_d = TW'(0);
                if (anim_frame_q == FW'(FRAMES - 1)) begin
                    anim_frame_d = FW'(0);
                end else begin
                    anim_frame_d = anim_frame_q + FW'(1);
                end
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end else begin
            tick_d       = tick_q;
            anim_frame_d = anim_frame_q;
        end
    end

    // Pixel pipeline registers; reset drops everything in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q   <= {ADDR_W{1'b0}};
            inside_p1_q  <= 1'b0;
            valid_p1_q   <= 1'b0;
            inside_p2_q  <= 1'b0;
            valid_p2_q   <= 1'b0;
            pal_index_q  <= TIDX;
            pix_opaque_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            rom_addr_q   <= rom_addr_d;
            inside_p1_q  <= inside_s;
            valid_p1_q   <= pix_valid;
            inside_p2_q  <= inside_p1_q;
            valid_p2_q   <= valid_p1_q;
            pal_index_q  <= pal_index_d;
            pix_opaque_q <= pix_opaque_d;
            out_valid_q  <= valid_p2_q;
        end
    end

    // Animation tick and frame registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tick_q       <= TW'(0);
            anim_frame_q <= FW'(0);
        end else begin
            tick_q       <= tick_d;
            anim_frame_q <= anim_frame_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign pal_index  = pal_index_q;
    assign pix_opaque = pix_opaque_q;
    assign out_valid  = out_valid_q;
    assign anim_frame = anim_frame_q;

endmodule

// File: doc/kyo_stand_fetch.md
# kyo_stand_fetch

Sprite pixel fetcher for the Kyo standing animation. It sits between the VGA pixel counter and the Kyo stand palette lookup. For every active-display pixel it decides whether the pixel lies inside the sprite box and, if so, computes the sprite ROM address, with horizontal flip for facing and an animation frame offset. It then returns the 4-bit palette index plus an opaque flag to the palette/compositing stage. It also owns the stand-animation frame counter, which advances only at frame boundaries.

## Interface
Parameters:
- SPRITE_W, 64: sprite width in pixels.
- SPRITE_H, 112: sprite height in pixels.
- FRAMES, 4: animation frames stored back-to-back in ROM.
- FRAME_TICKS, 8: frame_start pulses per animation frame.
- ADDR_W, 15: ROM address width; must satisfy 2^ADDR_W ≥ SPRITE_W·SPRITE_H·FRAMES.
- TRANSPARENT_IDX, 15: palette index treated as transparent (magenta key).

Ports:
- Clk  in  1  system/pixel clock; all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- pix_valid  in  1  DrawX/DrawY is an active-display pixel this cycle.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- SpriteX  in  10  sprite top-left column.
- SpriteY  in  10  sprite top-left row.
- facing_left  in  1  1 = mirror sprite horizontally.
- anim_en  in  1  1 = animation advances.
- rom_addr  out  ADDR_W  address to synchronous sprite ROM.
- rom_data  in  4  ROM output, valid one edge after rom_addr.
- pal_index  out  4  palette index to the palette lookup.
- pix_opaque  out  1  pixel is inside the sprite and not transparent.
- out_valid  out  1  pal_index/pix_opaque correspond to a valid pixel.
- anim_frame  out  $clog2(FRAMES)  current animation frame.

## Operation
- Stage 0 (combinational on inputs):
  - relX = DrawX − SpriteX and relY = DrawY − SpriteY, computed as 11-bit signed values. No modular wrap is permitted.
  - inside = pix_valid ∧ 0 ≤ relX < SPRITE_W ∧ 0 ≤ relY < SPRITE_H.
  - col = facing_left ? SPRITE_W−1−relX : relX.
  - addr = anim_frame·SPRITE_W·SPRITE_H + relY·SPRITE_W + col.
- Stage 1 register:
  - rom_addr ← addr when inside; otherwise rom_addr holds its previous value.
  - inside and pix_valid are delayed alongside it.
- Stage 2: the ROM registers rom_data. The inside and pix_valid flags are delayed one more stage.
- Stage 3 output register:
  - pal_index ← inside_d2 ? rom_data : TRANSPARENT_IDX.
  - pix_opaque ← inside_d2 ∧ rom_data ≠ TRANSPARENT_IDX.
  - out_valid ← pix_valid_d2.
- Animation counter:
  - tick counter is 0..FRAME_TICKS−1.
  - On frame_start with anim_en=1: if tick = FRAME_TICKS−1, then tick ← 0 and anim_frame ← (anim_frame+1) mod FRAMES; otherwise tick ← tick+1.
  - anim_en=0: tick and anim_frame hold, including when frame_start is asserted.
- Boundary cases:
  - Sprite partly off-screen: handled by the signed relX/relY compare. No address is produced for pixels outside the box.
  - A SpriteX/DrawX difference across the 1023→0 boundary is outside, never aliased.
  - A frame_start coinciding with pix_valid: the new anim_frame applies to addresses computed from the next cycle.

## Timing
- Latency is 3 rising edges from an input pixel to its pal_index/pix_opaque/out_valid. The pipeline is fully streaming, one pixel per cycle, with no stalls.
- rom_addr is registered 1 edge after the input. rom_data must be valid 1 edge after rom_addr.
- anim_frame is registered and updates on the edge that samples frame_start.
- Reset (async, Reset_n=0) takes effect immediately, including mid-line. Reset values:
  - rom_addr = 0.
  - pal_index = TRANSPARENT_IDX.
  - pix_opaque = 0.
  - out_valid = 0.
  - anim_frame = 0.
  - tick = 0.
  - All pipeline flags = 0.
- Pixels in flight at reset are dropped.

## Test plan
- Hit, right-facing:
  - Stimulus: SpriteX=100, SpriteY=200, facing_left=0, frame 0, DrawX=100, DrawY=200, pix_valid=1; ROM returns 3.
  - Response: rom_addr=0 after 1 edge; pal_index=3, pix_opaque=1, out_valid=1 after 3 edges.
- Flip: facing_left=1, DrawX=100, DrawY=201 -> rom_addr=127. With DrawX=163 -> rom_addr=64.
- Box edges, with pix_valid=1:
  - DrawX=164 (relX=64): pal_index=15, pix_opaque=0, out_valid=1, rom_addr unchanged.
  - DrawX=99: same response.
  - DrawY=312: same response.
- Transparency and blanking:
  - Inside pixel with ROM returning 15 -> pix_opaque=0, pal_index=15.
  - pix_valid=0 -> out_valid=0 after 3 edges.
- Animation:
  - anim_en=1, 8 frame_start pulses -> anim_frame=1. Inside pixel (0,0) at anim_frame=2 -> rom_addr=14336.
  - 32 pulses -> anim_frame wraps to 0.
  - anim_en=0 with pulses -> anim_frame unchanged.
- Reset mid-stream: drop Reset_n while out_valid=1 and anim_frame=2 -> immediately out_valid=0, pix_opaque=0, pal_index=15, anim_frame=0, rom_addr=0. The first pixel after release appears 3 edges later.
